// File: rtl/rf_pkg.sv
// Shared types and default sizing for the parametrised register file.
package rf_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    DONE
  } rf_state_t;

  localparam int RF_DATA_W = 4;
  localparam int RF_DEPTH  = 4;

endpackage

// File: rtl/rf_param_if.sv
// Bus bundle between the operand source (master) and the register file (slave).
interface rf_param_if
  import rf_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = $clog2(RF_DEPTH)
);

  logic              we;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] wd;
  logic [ADDR_W-1:0] sa;
  logic [ADDR_W-1:0] sb;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic              va;
  logic              vb;
  logic              clr_req;
  logic              busy;
  logic              clr_done;
  logic              wr_drop;

  modport master (
    output we, wa, wd, sa, sb, clr_req,
    input  a, b, va, vb, busy, clr_done, wr_drop
  );

  modport slave (
    input  we, wa, wd, sa, sb, clr_req,
    output a, b, va, vb, busy, clr_done, wr_drop
  );

endinterface

// File: rtl/rf_read_port.sv
// One combinational read port: storage mux with optional same-cycle write forwarding.
module rf_read_port
  import rf_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int DEPTH  = RF_DEPTH,
  parameter int BYPASS = 1,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0][DATA_W-1:0] regs,
  input  logic [DEPTH-1:0]             valid,
  input  logic [ADDR_W-1:0]            addr,
  input  logic                         fwd_en,
  input  logic [ADDR_W-1:0]            wa,
  input  logic [DATA_W-1:0]            wd,
  output logic [DATA_W-1:0]            data,
  output logic                         vld
);

  logic hit;

  // fwd_en already excludes busy cycles, so dropped writes never forward
  always_comb begin
    hit  = (BYPASS != 0) && fwd_en && (wa == addr);
    data = hit ? wd : regs[addr];
    vld  = hit ? 1'b1 : valid[addr];
  end

endmodule

// File: rtl/rf_param.sv
// Parametrised 2-read/1-write register file with valid bits and a sequenced clear engine.
module rf_param
  import rf_pkg::*;
#(
  parameter  int DATA_W = RF_DATA_W,
  parameter  int DEPTH  = RF_DEPTH,
  parameter  int BYPASS = 1,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  rf_param_if.slave    bus
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  logic [DEPTH-1:0][DATA_W-1:0] regs;
  logic [DEPTH-1:0]             valid;
  logic [ADDR_W-1:0]            ptr;
  rf_state_t                    state, next_state;
  logic                         busy, clr_done, wr_en;
  logic [DATA_W-1:0]            a_data, b_data;
  logic                         a_vld, b_vld;

  always_comb begin
    next_state = state;
    busy       = 1'b0;
    clr_done   = 1'b0;
    case (state)
      IDLE:  if (bus.clr_req) next_state = CLEAR;
      CLEAR: begin
        busy = 1'b1;
        if (ptr == LAST) next_state = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        clr_done   = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign wr_en = bus.we && !busy;

  // Writes only happen in IDLE, so they never collide with the clear pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      regs  <= '0;
      valid <= '0;
    end else begin
      state <= next_state;
      if (state == CLEAR) begin
        regs[ptr]  <= '0;
        valid[ptr] <= 1'b0;
        ptr        <= (ptr == LAST) ? '0 : ptr + ADDR_W'(1);
      end
      if (wr_en) begin
        regs[bus.wa]  <= bus.wd;
        valid[bus.wa] <= 1'b1;
      end
    end
  end

  rf_read_port #(.DATA_W(DATA_W), .DEPTH(DEPTH), .BYPASS(BYPASS), .ADDR_W(ADDR_W)) u_port_a (
    .regs   (regs),
    .valid  (valid),
    .addr   (bus.sa),
    .fwd_en (wr_en),
    .wa     (bus.wa),
    .wd     (bus.wd),
    .data   (a_data),
    .vld    (a_vld)
  );

  rf_read_port #(.DATA_W(DATA_W), .DEPTH(DEPTH), .BYPASS(BYPASS), .ADDR_W(ADDR_W)) u_port_b (
    .regs   (regs),
    .valid  (valid),
    .addr   (bus.sb),
    .fwd_en (wr_en),
    .wa     (bus.wa),
    .wd     (bus.wd),
    .data   (b_data),
    .vld    (b_vld)
  );

  assign bus.a        = a_data;
  assign bus.b        = b_data;
  assign bus.va       = a_vld;
  assign bus.vb       = b_vld;
  assign bus.busy     = busy;
  assign bus.clr_done = clr_done;
  assign bus.wr_drop  = bus.we && busy;

endmodule

// File: tb/tb_rf_param.sv
// Directed bench for rf_param: one bypassing and one non-bypassing instance share stimulus.
module tb_rf_param;
  import rf_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   passed;
  int   busy_cnt, done_cnt, done_pos;
  logic seen;

  rf_param_if #(.DATA_W(4), .ADDR_W(2)) if1 ();
  rf_param_if #(.DATA_W(4), .ADDR_W(2)) if0 ();

  rf_param #(.DATA_W(4), .DEPTH(4), .BYPASS(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
  rf_param #(.DATA_W(4), .DEPTH(4), .BYPASS(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic we, input logic [1:0] wa, input logic [3:0] wd,
                               input logic [1:0] sa, input logic [1:0] sb, input logic clr_req);
    if1.we = we; if1.wa = wa; if1.wd = wd; if1.sa = sa; if1.sb = sb; if1.clr_req = clr_req;
    if0.we = we; if0.wa = wa; if0.wd = wd; if0.sa = sa; if0.sb = sb; if0.clr_req = clr_req;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs === exp) passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [1:0] wa, input logic [3:0] wd);
    applyStimulus(1'b1, wa, wd, 2'd0, 2'd0, 1'b0);
    tick();
    applyStimulus(1'b0, 2'd0, 4'h0, 2'd0, 2'd0, 1'b0);
  endtask

  initial begin
    checks = 0;
    passed = 0;
    rst    = 1'b1;
    applyStimulus(1'b0, 2'd0, 4'h0, 2'd0, 2'd3, 1'b0);
    tick();
    rst = 1'b0;

    // reset state
    #1;
    checkOutput("rst_a", if1.a, 4'h0);
    checkOutput("rst_b", if1.b, 4'h0);
    checkOutput("rst_va", if1.va, 1'b0);
    checkOutput("rst_vb", if1.vb, 1'b0);
    checkOutput("rst_busy", if1.busy, 1'b0);
    checkOutput("rst_done", if1.clr_done, 1'b0);

    // write then read through storage
    write(2'd2, 4'hA);
    applyStimulus(1'b0, 2'd0, 4'h0, 2'd2, 2'd1, 1'b0);
    #1;
    checkOutput("wr_a", if1.a, 4'hA);
    checkOutput("wr_va", if1.va, 1'b1);
    checkOutput("wr_b", if1.b, 4'h0);
    checkOutput("wr_vb", if1.vb, 1'b0);

    // same-cycle forwarding vs storage-only read
    applyStimulus(1'b1, 2'd1, 4'h5, 2'd1, 2'd2, 1'b0);
    #1;
    checkOutput("byp1_a", if1.a, 4'h5);
    checkOutput("byp1_va", if1.va, 1'b1);
    checkOutput("byp0_a", if0.a, 4'h0);
    checkOutput("byp0_va", if0.va, 1'b0);
    checkOutput("byp_b", if1.b, 4'hA);
    checkOutput("byp_drop", if1.wr_drop, 1'b0);
    tick();
    applyStimulus(1'b0, 2'd0, 4'h0, 2'd1, 2'd2, 1'b0);
    #1;
    checkOutput("byp0_stored_a", if0.a, 4'h5);
    checkOutput("byp0_stored_va", if0.va, 1'b1);

    // full clear sequence
    write(2'd0, 4'h1);
    write(2'd1, 4'h2);
    write(2'd2, 4'h3);
    write(2'd3, 4'h4);
    applyStimulus(1'b0, 2'd0, 4'h0, 2'd0, 2'd3, 1'b1);
    tick();
    applyStimulus(1'b0, 2'd0, 4'h0, 2'd0, 2'd3, 1'b0);
    busy_cnt = 0; done_cnt = 0; done_pos = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (if1.busy) busy_cnt++;
      if (if1.clr_done) begin
        done_cnt++;
        done_pos = busy_cnt;
      end
      if (i == 1) begin
        checkOutput("clr_mid_a", if1.a, 4'h0);
        checkOutput("clr_mid_va", if1.va, 1'b0);
        checkOutput("clr_mid_b", if1.b, 4'h4);
        checkOutput("clr_mid_vb", if1.vb, 1'b1);
      end
      tick();
    end
    checkOutput("clr_busy_cycles", busy_cnt, 5);
    checkOutput("clr_done_count", done_cnt, 1);
    checkOutput("clr_done_pos", done_pos, 5);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 2'd0, 4'h0, 2'(k), 2'(k), 1'b0);
      #1;
      checkOutput($sformatf("clr_after_a%0d", k), if1.a, 4'h0);
      checkOutput($sformatf("clr_after_va%0d", k), if1.va, 1'b0);
    end

    // write and clr_req during a clear are ignored
    write(2'd3, 4'h7);
    applyStimulus(1'b0, 2'd0, 4'h0, 2'd3, 2'd3, 1'b1);
    tick();
    applyStimulus(1'b0, 2'd0, 4'h0, 2'd3, 2'd3, 1'b0);
    tick();
    applyStimulus(1'b1, 2'd3, 4'hF, 2'd3, 2'd3, 1'b1);
    #1;
    checkOutput("drop_flag", if1.wr_drop, 1'b1);
    checkOutput("drop_nobyp_a", if1.a, 4'h7);
    checkOutput("drop_nobyp_va", if1.va, 1'b1);
    tick();
    applyStimulus(1'b0, 2'd0, 4'h0, 2'd3, 2'd3, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (if1.clr_done) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    checkOutput("drop_done_seen", seen, 1'b1);
    tick();
    busy_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (if1.busy) busy_cnt++;
      tick();
    end
    checkOutput("drop_no_requeue", busy_cnt, 0);
    #1;
    checkOutput("drop_reg3", if1.a, 4'h0);
    checkOutput("drop_valid3", if1.va, 1'b0);

    // reset aborts a clear in progress
    write(2'd2, 4'h9);
    applyStimulus(1'b0, 2'd0, 4'h0, 2'd2, 2'd2, 1'b1);
    tick();
    applyStimulus(1'b0, 2'd0, 4'h0, 2'd2, 2'd2, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    applyStimulus(1'b1, 2'd0, 4'h6, 2'd1, 2'd2, 1'b0);
    #1;
    checkOutput("abort_busy", if1.busy, 1'b0);
    checkOutput("abort_drop", if1.wr_drop, 1'b0);
    checkOutput("abort_b", if1.b, 4'h0);
    checkOutput("abort_vb", if1.vb, 1'b0);
    done_cnt = 0;
    if (if1.clr_done) done_cnt++;
    tick();
    applyStimulus(1'b0, 2'd0, 4'h0, 2'd0, 2'd2, 1'b0);
    for (int i = 0; i < 6; i++) begin
      #1;
      if (if1.clr_done) done_cnt++;
      tick();
    end
    checkOutput("abort_no_done", done_cnt, 0);
    checkOutput("abort_wr_a", if1.a, 4'h6);
    checkOutput("abort_wr_va", if1.va, 1'b1);
    checkOutput("abort_reg2", if1.b, 4'h0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
